// File: rtl/mips_pkg.sv
// mips_pkg: boot sequencer header type codes, header field bit positions and FSM state encoding
package mips_pkg;
  localparam logic [1:0] HDR_IMEM = 2'b00;
  localparam logic [1:0] HDR_DMEM = 2'b01;
  localparam logic [1:0] HDR_GO   = 2'b10;
  localparam logic [1:0] HDR_RSVD = 2'b11;
  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int CNT_HI  = 29;
  localparam int CNT_LO  = 16;
  localparam int BASE_HI = 15;
  localparam int BASE_LO = 0;
  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_ILOAD = 3'd1;
  localparam logic [2:0] S_DLOAD = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
endpackage

// File: rtl/boot_run_timer.sv
// boot_run_timer: cycle budget counter; load latches budget and clears count, en counts, expired flags the last enabled cycle of a nonzero budget
module boot_run_timer #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] budget,
  output logic         expired
);
  logic [W-1:0] cnt, lim;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      lim <= '0;
    end else if (load) begin
      cnt <= '0;
      lim <= budget;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  assign expired = en && |lim && cnt == lim - 1'b1;
endmodule

// File: rtl/mips_boot_sequencer.sv
// mips_boot_sequencer: streams IMEM/DMEM images into MIPS_top loader ports (I*/D* addr, data, we) from s_valid/s_data/s_ready, runs start for a GO budget, reports loading/done/err/words_loaded
module mips_boot_sequencer
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RUN_CNT_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  input  logic              abort,
  output logic [ADDR_W-1:0] IAddr_in,
  output logic [31:0]       IData_in,
  output logic              icache_we,
  output logic [ADDR_W-1:0] DAddr_in,
  output logic [31:0]       DData_in,
  output logic              dcache_we,
  output logic              start,
  output logic              loading,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);
  logic [2:0] state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_HI-CNT_LO:0] remaining;
  logic [1:0] typ;
  logic acc, expired, go_acc;
  assign loading = state == S_ILOAD || state == S_DLOAD;
  assign s_ready = (state == S_HDR || loading) && !abort;
  assign acc = s_valid && s_ready;
  assign typ = s_data[TYPE_HI:TYPE_LO];
  assign start = state == S_RUN;
  assign err = state == S_ERR;
  assign go_acc = state == S_HDR && acc && typ == HDR_GO;
  boot_run_timer #(.W(RUN_CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(go_acc),
    .en(start),
    .budget(s_data[RUN_CNT_W-1:0]),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_HDR;
      addr <= '0;
      remaining <= '0;
      IAddr_in <= '0;
      IData_in <= '0;
      icache_we <= 1'b0;
      DAddr_in <= '0;
      DData_in <= '0;
      dcache_we <= 1'b0;
      done <= 1'b0;
      words_loaded <= '0;
    end else begin
      icache_we <= 1'b0;
      dcache_we <= 1'b0;
      if (abort && state != S_ERR) state <= S_HDR;
      else case (state)
        S_HDR: if (acc) begin
          done <= 1'b0;
          addr <= ADDR_W'(s_data[BASE_HI:BASE_LO]);
          remaining <= s_data[CNT_HI:CNT_LO];
          case (typ)
            HDR_IMEM, HDR_DMEM: state <= ~|s_data[CNT_HI:CNT_LO] ? S_HDR : typ == HDR_IMEM ? S_ILOAD : S_DLOAD;
            HDR_GO:   state <= S_RUN;
            HDR_RSVD: state <= S_ERR;
          endcase
        end
        S_ILOAD, S_DLOAD: if (acc) begin
          if (state == S_ILOAD) begin
            IAddr_in <= addr;
            IData_in <= s_data;
            icache_we <= 1'b1;
          end else begin
            DAddr_in <= addr;
            DData_in <= s_data;
            dcache_we <= 1'b1;
          end
          addr <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          words_loaded <= words_loaded + {15'd0, ~&words_loaded};
          if (remaining == 14'd1) state <= S_HDR;
        end
        S_RUN: if (expired) begin
          state <= S_HDR;
          done <= 1'b1;
        end
        S_ERR: ;
        default: state <= S_HDR;
      endcase
    end
endmodule

// File: tb/tb_mips_boot_sequencer.sv
// tb_mips_boot_sequencer: directed stream vectors against a per-cycle behavioural model plus literal expectations
module tb_mips_boot_sequencer;
  logic clk = 0, rst = 0, s_valid = 0, abort = 0;
  logic [31:0] s_data = 0;
  logic s_ready, icache_we, dcache_we, start, loading, done, err;
  logic [31:0] IAddr_in, IData_in, DAddr_in, DData_in;
  logic [15:0] words_loaded;
  int checks = 0, errors = 0;
  int n_iwe = 0, n_dwe = 0, n_start = 0, base_i, base_d;
  bit chk_en = 0;
  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] m_imem [logic [31:0]];
  logic [31:0] m_dmem [logic [31:0]];
  always #5 clk = ~clk;
  mips_boot_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .abort(abort),
    .IAddr_in(IAddr_in), .IData_in(IData_in), .icache_we(icache_we),
    .DAddr_in(DAddr_in), .DData_in(DData_in), .dcache_we(dcache_we),
    .start(start), .loading(loading), .done(done), .err(err), .words_loaded(words_loaded)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  int m_mode;
  logic [31:0] m_left, m_addr, m_ia, m_id, m_da, m_dd;
  logic [29:0] m_run_left;
  logic m_iwe, m_dwe, m_done, m_ready, m_acc;
  logic [15:0] m_words;
  assign m_ready = m_mode <= 2 && !abort;
  assign m_acc = s_valid && m_ready;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_mode <= 0;
      m_left <= 0;
      m_run_left <= 0;
      m_addr <= 0;
      m_ia <= 0;
      m_id <= 0;
      m_da <= 0;
      m_dd <= 0;
      m_iwe <= 0;
      m_dwe <= 0;
      m_done <= 0;
      m_words <= 0;
    end else begin
      m_iwe <= 0;
      m_dwe <= 0;
      if (abort && m_mode != 4) m_mode <= 0;
      else if (m_mode == 0 && m_acc) begin
        m_done <= 0;
        if (s_data[31] == 1'b0) begin
          m_addr <= {16'd0, s_data[15:0]};
          m_left <= {18'd0, s_data[29:16]};
          if (s_data[29:16] != 0) m_mode <= s_data[30] ? 2 : 1;
        end else if (s_data[30] == 1'b0) begin
          m_mode <= 3;
          m_run_left <= s_data[29:0];
        end else m_mode <= 4;
      end else if ((m_mode == 1 || m_mode == 2) && m_acc) begin
        if (m_mode == 1) begin
          m_iwe <= 1;
          m_ia <= m_addr;
          m_id <= s_data;
        end else begin
          m_dwe <= 1;
          m_da <= m_addr;
          m_dd <= s_data;
        end
        m_addr <= m_addr + 1;
        m_words <= m_words == 16'hFFFF ? m_words : m_words + 16'd1;
        m_left <= m_left - 1;
        if (m_left == 1) m_mode <= 0;
      end else if (m_mode == 3 && m_run_left != 0) begin
        m_run_left <= m_run_left - 1;
        if (m_run_left == 1) begin
          m_mode <= 0;
          m_done <= 1;
        end
      end
    end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", s_ready, m_ready);
      chk("start", start, m_mode == 3);
      chk("loading", loading, m_mode == 1 || m_mode == 2);
      chk("err", err, m_mode == 4);
      chk("done", done, m_done);
      chk("icache_we", icache_we, m_iwe);
      chk("dcache_we", dcache_we, m_dwe);
      chk("IAddr_in", IAddr_in, m_ia);
      chk("IData_in", IData_in, m_id);
      chk("DAddr_in", DAddr_in, m_da);
      chk("DData_in", DData_in, m_dd);
      chk("words_loaded", words_loaded, m_words);
      chk("we_exclusive", icache_we && dcache_we, 0);
    end
    if (icache_we) begin imem[IAddr_in] = IData_in; n_iwe++; end
    if (dcache_we) begin dmem[DAddr_in] = DData_in; n_dwe++; end
    if (m_iwe) m_imem[m_ia] = m_id;
    if (m_dwe) m_dmem[m_da] = m_dd;
    if (start) n_start++;
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [31:0] w);
    bit ok;
    int n = 0;
    s_valid = 1;
    s_data = w;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 20);
    #1 s_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #1 rst = 1;
    #2;
    chk("rst_start", start, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_iwe", icache_we, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_s_ready", s_ready, 1);
    chk_en = 1;
    @(posedge clk);
    #1 rst = 0;
    idle(1);
    send(32'h0003_0000);
    send(32'h8C08_0000);
    send(32'h2009_0001);
    send(32'h200A_000A);
    idle(3);
    chk("t1_words", words_loaded, 3);
    chk("t1_iwe_cnt", n_iwe, 3);
    chk("t1_dwe_cnt", n_dwe, 0);
    chk("t1_imem0", imem[0], 32'h8C08_0000);
    chk("t1_imem1", imem[1], 32'h2009_0001);
    chk("t1_imem2", imem[2], 32'h200A_000A);
    send(32'h4002_0005);
    send(32'd923);
    idle(1);
    send(32'd7);
    idle(3);
    chk("t2_dwe_cnt", n_dwe, 2);
    chk("t2_dmem5", dmem[5], 32'd923);
    chk("t2_dmem6", dmem[6], 32'd7);
    chk("t2_words", words_loaded, 5);
    n_start = 0;
    send(32'h8000_0004);
    idle(8);
    chk("t3_start_cycles", n_start, 4);
    chk("t3_done", done, 1);
    send(32'h0000_0000);
    idle(1);
    chk("t3_done_clr", done, 0);
    base_i = n_iwe;
    send(32'h0005_0010);
    send(32'h1111_0001);
    send(32'h1111_0002);
    s_valid = 1;
    s_data = 32'h1111_0003;
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    s_valid = 0;
    idle(3);
    chk("t5_writes", n_iwe - base_i, 2);
    chk("t5_loading", loading, 0);
    chk("t5_imem11", imem[32'h11], 32'h1111_0002);
    send(32'h0001_0020);
    send(32'h1234_5678);
    idle(2);
    chk("t5_imem20", imem[32'h20], 32'h1234_5678);
    send(32'hC000_0000);
    idle(2);
    chk("t4_err", err, 1);
    chk("t4_s_ready", s_ready, 0);
    base_i = n_iwe;
    base_d = n_dwe;
    s_valid = 1;
    s_data = 32'h0001_0040;
    idle(5);
    s_valid = 0;
    chk("t4_no_iwe", n_iwe - base_i, 0);
    chk("t4_no_dwe", n_dwe - base_d, 0);
    chk("t4_err_sticky", err, 1);
    rst = 1;
    #2;
    chk("t4_err_clr", err, 0);
    @(posedge clk);
    #1 rst = 0;
    idle(1);
    send(32'h8000_0000);
    idle(100);
    chk("t6_running", start, 1);
    #2 rst = 1;
    #1;
    chk("t6_start_async", start, 0);
    chk("t6_iwe", icache_we, 0);
    chk("t6_dwe", dcache_we, 0);
    chk("t6_done", done, 0);
    chk("t6_loading", loading, 0);
    chk("t6_words", words_loaded, 0);
    @(posedge clk);
    #1 rst = 0;
    idle(2);
    chk("imem_size", imem.size(), m_imem.size());
    chk("dmem_size", dmem.size(), m_dmem.size());
    foreach (m_imem[k]) chk("imem_content", imem[k], m_imem[k]);
    foreach (m_dmem[k]) chk("dmem_content", dmem[k], m_dmem[k]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
